// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: operand/opcode request and result/status bundle for alu_multicycle
interface alu_multicycle_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r2;
  logic             z;
  logic             ovf;
  logic             dz;
  logic             busy;
  logic             done;
  modport master (output start, ctrl, a, b, input r, r2, z, ovf, dz, busy, done);
  modport slave  (input start, ctrl, a, b, output r, r2, z, ovf, dz, busy, done);
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: single-cycle ALU ops plus iterative shift-add multiply and restoring divide
module alu_multicycle #(
  parameter int WIDTH    = 32,
  parameter int CLIP_MAX = 255
) (
  input logic clock,
  input logic reset,
  alu_multicycle_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] CMAX = WIDTH'(CLIP_MAX);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nx;
  logic [SW-1:0] cnt;
  logic [2*WIDTH-1:0] p, p_nx, prod;
  logic [WIDTH-1:0] mcand, q, rem, q_nx, rem_nx, qf, rf, fin_lo, fin_hi;
  logic [WIDTH-1:0] hi, lo, ma, mb, sum, dif, s_r, s_r2;
  logic [WIDTH:0] msum, dsh, ddf;
  logic [5:0] op;
  logic sgn_q, sgn_r, accept, is_mul, is_div, is_dz, sgn, last, s_ovf;
  assign op = bus.ctrl;
  always_ff @(posedge clock)
    state <= !reset ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (accept && is_mul ? MUL : accept && is_div ? DIV : IDLE)
                             : (last ? IDLE : state);
  always_comb begin
    accept = bus.start && state == IDLE;
    is_mul = op == 6'h13 || op == 6'h15;
    is_dz  = (op == 6'h16 || op == 6'h17) && bus.b == '0;
    is_div = (op == 6'h16 || op == 6'h17) && !is_dz;
    sgn    = op == 6'h15 || op == 6'h17;
    last   = cnt == SW'(WIDTH - 1);
    bus.busy = state != IDLE;
    ma = sgn && bus.a[WIDTH-1] ? -bus.a : bus.a;
    mb = sgn && bus.b[WIDTH-1] ? -bus.b : bus.b;
    // one shift-add / restoring step on unsigned magnitudes; sign fixed up on the last step
    msum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, p[0] ? mcand : {WIDTH{1'b0}}};
    p_nx   = {msum, p[WIDTH-1:1]};
    dsh    = {rem, q[WIDTH-1]};
    ddf    = dsh - {1'b0, mcand};
    rem_nx = ddf[WIDTH] ? dsh[WIDTH-1:0] : ddf[WIDTH-1:0];
    q_nx   = {q[WIDTH-2:0], ~ddf[WIDTH]};
    prod   = sgn_q ? -p_nx : p_nx;
    qf     = sgn_q ? -q_nx : q_nx;
    rf     = sgn_r ? -rem_nx : rem_nx;
    fin_lo = state == MUL ? prod[WIDTH-1:0] : qf;
    fin_hi = state == MUL ? prod[2*WIDTH-1:WIDTH] : rf;
    sum   = bus.a + bus.b;
    dif   = bus.a - bus.b;
    s_r   = '0;
    s_r2  = '0;
    s_ovf = 1'b0;
    case (op)
      6'h00: s_r = bus.a & bus.b;
      6'h01: s_r = bus.a | bus.b;
      6'h02: begin
        s_r   = sum;
        s_ovf = bus.a[WIDTH-1] == bus.b[WIDTH-1] && sum[WIDTH-1] != bus.a[WIDTH-1];
      end
      6'h03: s_r = sum;
      6'h04: s_r = bus.a ^ bus.b;
      6'h05: s_r = ~(bus.a | bus.b);
      6'h06: begin
        s_r   = dif;
        s_ovf = bus.a[WIDTH-1] != bus.b[WIDTH-1] && dif[WIDTH-1] != bus.a[WIDTH-1];
      end
      6'h07: s_r = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      6'h08: s_r = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      6'h09: s_r = bus.b << (WIDTH/2);
      6'h0A: s_r = bus.b << 1;
      6'h0B: s_r = bus.b << 2;
      6'h0C: s_r = bus.b << 8;
      6'h0D: s_r = bus.b >> 1;
      6'h0E: s_r = bus.b >> 2;
      6'h0F: s_r = bus.b >> 8;
      6'h10: s_r = $signed(bus.b) >>> 1;
      6'h11: s_r = $signed(bus.b) >>> 2;
      6'h12: s_r = $signed(bus.b) >>> 8;
      6'h14: s_r = bus.a[WIDTH-1] ? '0 : bus.a > CMAX ? CMAX : bus.a;
      6'h16, 6'h17: begin
        s_r  = '1;
        s_r2 = bus.a;
      end
      6'h18: s_r = bus.b << bus.a[SW-1:0];
      6'h19: s_r = bus.b >> bus.a[SW-1:0];
      6'h1A: s_r = $signed(bus.b) >>> bus.a[SW-1:0];
      6'h1B: s_r = hi;
      6'h1C: s_r = lo;
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      bus.r    <= '0;
      bus.r2   <= '0;
      bus.z    <= 1'b1;
      bus.ovf  <= 1'b0;
      bus.dz   <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      cnt <= state == IDLE ? '0 : cnt + 1'b1;
      if (accept && !is_mul && !is_div) begin
        bus.r    <= s_r;
        bus.r2   <= s_r2;
        bus.z    <= s_r == '0;
        bus.ovf  <= s_ovf;
        bus.dz   <= is_dz;
        bus.done <= 1'b1;
        if (is_dz) begin
          hi <= bus.a;
          lo <= '1;
        end
      end
      if (accept) begin
        mcand <= is_mul ? ma : mb;
        p     <= {{WIDTH{1'b0}}, mb};
        q     <= ma;
        rem   <= '0;
        sgn_q <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        sgn_r <= sgn && bus.a[WIDTH-1];
      end
      if (state == MUL) p <= p_nx;
      if (state == DIV) begin
        q   <= q_nx;
        rem <= rem_nx;
      end
      if (state != IDLE && last) begin
        hi       <= fin_hi;
        lo       <= fin_lo;
        bus.r    <= fin_lo;
        bus.r2   <= fin_hi;
        bus.z    <= fin_lo == '0;
        bus.ovf  <= 1'b0;
        bus.dz   <= 1'b0;
        bus.done <= 1'b1;
      end
    end
  end
endmodule
